// File: rtl/if_id_pipe_reg_pkg.sv
// Shared widths, hazard-mode bit positions, NOP encoding and IF/ID occupancy states.
// No logic of its own: no latency, no backpressure.
`ifndef INST_WIDTH
`define INST_WIDTH 32
`endif
`ifndef SYS_ADDR_SPACE
`define SYS_ADDR_SPACE 32
`endif

package if_id_pipe_reg_pkg;

  localparam int          FLUSH_BIT = 0;
  localparam int          STALL_BIT = 1;
  localparam logic [31:0] NOP_ENC   = 32'h0000_0013;  // addi x0,x0,0

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } pipe_state_e;

endpackage

// File: rtl/if_id_pipe_reg_if.sv
// Fetch/decode handshake bundle between IF, the IF/ID register and ID, plus the hazard mode.
// Wires only: no latency; ready/valid carried unchanged.
interface if_id_pipe_reg_if #(
  parameter int ADDR_W = `SYS_ADDR_SPACE,
  parameter int INST_W = `INST_WIDTH
);
  logic [1:0]        mode_i;
  logic              in_valid_i;
  logic              in_ready_o;
  logic [ADDR_W-1:0] pc_i;
  logic [INST_W-1:0] instr_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [ADDR_W-1:0] pc_o;
  logic [INST_W-1:0] instr_o;

  // master: the surrounding pipeline (fetch, decode, hazard unit)
  modport master (
    output mode_i, in_valid_i, pc_i, instr_i, out_ready_i,
    input  in_ready_o, out_valid_o, pc_o, instr_o
  );

  // slave: the IF/ID register itself
  modport slave (
    input  mode_i, in_valid_i, pc_i, instr_i, out_ready_i,
    output in_ready_o, out_valid_o, pc_o, instr_o
  );
endinterface

// File: rtl/if_id_pipe_reg_entry.sv
// One {valid, pc, instr} slot with clear > load > hold priority; clear leaves a NOP bubble.
// Latency 1 cycle; no backpressure of its own, the owner decides when to load.
module pipe_entry_reg
  import if_id_pipe_reg_pkg::*;
#(
  parameter int                ADDR_W    = `SYS_ADDR_SPACE,
  parameter int                INST_W    = `INST_WIDTH,
  parameter logic [INST_W-1:0] NOP_INSTR = INST_W'(NOP_ENC)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr,
  input  logic              ld,
  input  logic [ADDR_W-1:0] pc_d,
  input  logic [INST_W-1:0] instr_d,
  output logic              vld_q,
  output logic [ADDR_W-1:0] pc_q,
  output logic [INST_W-1:0] instr_q
);

  always_ff @(posedge clk_i) begin
    if (rst_i || clr) begin
      vld_q   <= 1'b0;
      pc_q    <= '0;
      instr_q <= NOP_INSTR;
    end else if (ld) begin
      vld_q   <= 1'b1;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

endmodule

// File: rtl/if_id_pipe_reg.sv
// IF->ID pipeline register, valid/ready with stall/flush and an optional 2-entry skid buffer.
// Latency 1 cycle; with SKID_EN=1 in_ready_o depends only on state and stall, else on out_ready_i.
module if_id_pipe_reg
  import if_id_pipe_reg_pkg::*;
#(
  parameter int                INST_W    = `INST_WIDTH,
  parameter int                ADDR_W    = `SYS_ADDR_SPACE,
  parameter logic [INST_W-1:0] NOP_INSTR = INST_W'(NOP_ENC),
  parameter bit                SKID_EN   = 1'b1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  if_id_pipe_reg_if.slave     bus
);

  pipe_state_e state_q, state_d;

  logic              stall, flush, in_rdy, out_vld, accept, dequeue;
  logic              main_ld, main_clr, main_from_skid, skid_ld, skid_clr;
  logic              main_vld, skid_vld;
  logic [ADDR_W-1:0] main_pc, skid_pc, main_pc_d;
  logic [INST_W-1:0] main_instr, skid_instr, main_instr_d;

  assign stall = bus.mode_i[STALL_BIT];
  assign flush = bus.mode_i[FLUSH_BIT] & ~stall;

  assign in_rdy = SKID_EN ? ((state_q != ST_TWO) & ~stall)
                          : ((~main_vld | bus.out_ready_i) & ~stall);

  // Gated by reset so no downstream handshake can complete in the reset cycle.
  assign out_vld = main_vld & ~rst_i;

  // A flushed input is acknowledged to IF but dropped here.
  assign accept  = bus.in_valid_i & in_rdy & ~flush;
  assign dequeue = out_vld & bus.out_ready_i & ~stall & ~flush;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_EMPTY;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    main_ld        = 1'b0;
    main_clr       = flush;
    main_from_skid = 1'b0;
    skid_ld        = 1'b0;
    skid_clr       = flush;
    if (flush) begin
      state_d = ST_EMPTY;
    end else if (!stall) begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            main_ld = 1'b1;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && dequeue) begin
            main_ld = 1'b1;
          end else if (accept) begin
            skid_ld = 1'b1;
            state_d = ST_TWO;
          end else if (dequeue) begin
            main_clr = 1'b1;
            state_d  = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (dequeue) begin
            main_ld        = 1'b1;
            main_from_skid = 1'b1;
            skid_clr       = 1'b1;
            state_d        = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  assign main_pc_d    = main_from_skid ? skid_pc    : bus.pc_i;
  assign main_instr_d = main_from_skid ? skid_instr : bus.instr_i;

  pipe_entry_reg #(.ADDR_W(ADDR_W), .INST_W(INST_W), .NOP_INSTR(NOP_INSTR)) u_main (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr     (main_clr),
    .ld      (main_ld),
    .pc_d    (main_pc_d),
    .instr_d (main_instr_d),
    .vld_q   (main_vld),
    .pc_q    (main_pc),
    .instr_q (main_instr)
  );

  pipe_entry_reg #(.ADDR_W(ADDR_W), .INST_W(INST_W), .NOP_INSTR(NOP_INSTR)) u_skid (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr     (skid_clr),
    .ld      (skid_ld),
    .pc_d    (bus.pc_i),
    .instr_d (bus.instr_i),
    .vld_q   (skid_vld),
    .pc_q    (skid_pc),
    .instr_q (skid_instr)
  );

  assign bus.in_ready_o  = in_rdy;
  assign bus.out_valid_o = out_vld;
  assign bus.pc_o        = out_vld ? main_pc    : '0;
  assign bus.instr_o     = out_vld ? main_instr : NOP_INSTR;

endmodule

// File: tb/tb_if_id_pipe_reg.sv
// Bench for if_id_pipe_reg: skid instance (A) scored against a FIFO scoreboard, no-skid instance (B) against tables.
module tb_if_id_pipe_reg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } item_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  if_id_pipe_reg_if #(.ADDR_W(32), .INST_W(32)) ifa ();
  if_id_pipe_reg_if #(.ADDR_W(32), .INST_W(32)) ifb ();

  if_id_pipe_reg #(.INST_W(32), .ADDR_W(32), .NOP_INSTR(32'h13), .SKID_EN(1'b1)) dut_a (
    .clk_i (clk), .rst_i (rst), .bus (ifa)
  );
  if_id_pipe_reg #(.INST_W(32), .ADDR_W(32), .NOP_INSTR(32'h13), .SKID_EN(1'b0)) dut_b (
    .clk_i (clk), .rst_i (rst), .bus (ifb)
  );

  int    chk_cnt  = 0;
  int    pass_cnt = 0;
  item_t sb[$];
  item_t exp_item;

  logic        obs_rdy, obs_vld, obs_deq, obs_acc, obs_under;
  logic [31:0] obs_pc, obs_instr;
  logic        b_rdy, b_vld;
  logic [31:0] b_pc, b_instr;

  task automatic drv(input logic v, input logic [31:0] p, input logic [31:0] ins,
                     input logic ordy, input logic [1:0] md);
    ifa.in_valid_i  = v;
    ifa.pc_i        = p;
    ifa.instr_i     = ins;
    ifa.out_ready_i = ordy;
    ifa.mode_i      = md;
  endtask

  task automatic drv_b(input logic v, input logic [31:0] p, input logic ordy);
    ifb.in_valid_i  = v;
    ifb.pc_i        = p;
    ifb.instr_i     = p ^ 32'h5A00_0000;
    ifb.out_ready_i = ordy;
    ifb.mode_i      = 2'b00;
  endtask

  // Samples both DUTs mid-cycle, updates the scoreboard for A, then advances past the next edge.
  task automatic step();
    @(negedge clk);
    obs_rdy   = ifa.in_ready_o;
    obs_vld   = ifa.out_valid_o;
    obs_pc    = ifa.pc_o;
    obs_instr = ifa.instr_o;
    b_rdy     = ifb.in_ready_o;
    b_vld     = ifb.out_valid_o;
    b_pc      = ifb.pc_o;
    b_instr   = ifb.instr_o;
    obs_deq   = 1'b0;
    obs_acc   = 1'b0;
    obs_under = 1'b0;
    if (rst === 1'b1) begin
      sb.delete();
    end else if (ifa.mode_i[1]) begin
      // stall: nothing moves
    end else if (ifa.mode_i[0]) begin
      sb.delete();
    end else begin
      if (obs_vld === 1'b1 && ifa.out_ready_i) begin
        obs_deq = 1'b1;
        if (sb.size() == 0) obs_under = 1'b1;
        else exp_item = sb.pop_front();
      end
      if (ifa.in_valid_i && obs_rdy === 1'b1) begin
        obs_acc = 1'b1;
        sb.push_back(item_t'{pc: ifa.pc_i, instr: ifa.instr_i});
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drv(1'b1, 32'h99, 32'h99, 1'b1, 2'b00);
    step();
    step();
    chk_cnt++; if (obs_vld !== 1'b0) $display("FAIL rst_hold_vld got=%b exp=0", obs_vld); else pass_cnt++;
    rst = 1'b0;
    drv(1'b0, 32'h0, 32'h0, 1'b1, 2'b00);
    step();
    chk_cnt++; if (obs_vld !== 1'b0) $display("FAIL rst_vld got=%b exp=0", obs_vld); else pass_cnt++;
    chk_cnt++; if (obs_pc !== 32'h0) $display("FAIL rst_pc got=%h exp=0", obs_pc); else pass_cnt++;
    chk_cnt++; if (obs_instr !== 32'h13) $display("FAIL rst_instr got=%h exp=13", obs_instr); else pass_cnt++;
    chk_cnt++; if (obs_rdy !== 1'b1) $display("FAIL rst_rdy got=%b exp=1", obs_rdy); else pass_cnt++;
    chk_cnt++; if (b_rdy !== 1'b1 || b_vld !== 1'b0) $display("FAIL rst_b got=%b%b exp=10", b_rdy, b_vld); else pass_cnt++;
  endtask

  task automatic test_streaming();
    for (int i = 0; i < 5; i++) begin
      if (i < 3) drv(1'b1, 32'(4 * i), 32'h1000 + 32'(i), 1'b1, 2'b00);
      else       drv(1'b0, 32'h0, 32'h0, 1'b1, 2'b00);
      step();
      if (i >= 1 && i <= 3) begin
        chk_cnt++;
        if (obs_deq !== 1'b1 || obs_under) $display("FAIL stream_vld cyc=%0d got=%b exp=1", i, obs_vld);
        else pass_cnt++;
        chk_cnt++;
        if ({obs_pc, obs_instr} !== {exp_item.pc, exp_item.instr})
          $display("FAIL stream_data got=%h/%h exp=%h/%h", obs_pc, obs_instr, exp_item.pc, exp_item.instr);
        else pass_cnt++;
        chk_cnt++;
        if (obs_pc !== 32'(4 * (i - 1))) $display("FAIL stream_order got=%h exp=%h", obs_pc, 32'(4 * (i - 1)));
        else pass_cnt++;
      end else begin
        chk_cnt++; if (obs_vld !== 1'b0) $display("FAIL stream_idle cyc=%0d got=%b exp=0", i, obs_vld); else pass_cnt++;
      end
    end
  endtask

  task automatic test_backpressure();
    logic        tv   [7] = '{1, 1, 1, 1, 1, 0, 0};
    logic [31:0] tpc  [7] = '{32'h10, 32'h14, 32'h18, 32'h18, 32'h18, 32'h0, 32'h0};
    logic        tord [7] = '{0, 0, 0, 1, 1, 1, 1};
    logic        erdy [7] = '{1, 1, 0, 0, 1, 1, 1};
    logic        evld [7] = '{0, 1, 1, 1, 1, 1, 0};
    logic [31:0] epc  [7] = '{32'h0, 32'h10, 32'h10, 32'h10, 32'h14, 32'h18, 32'h0};
    for (int i = 0; i < 7; i++) begin
      drv(tv[i], tpc[i], tpc[i] ^ 32'hA5A5_0000, tord[i], 2'b00);
      step();
      chk_cnt++; if (obs_rdy !== erdy[i]) $display("FAIL bp_rdy cyc=%0d got=%b exp=%b", i, obs_rdy, erdy[i]); else pass_cnt++;
      chk_cnt++; if (obs_vld !== evld[i]) $display("FAIL bp_vld cyc=%0d got=%b exp=%b", i, obs_vld, evld[i]); else pass_cnt++;
      chk_cnt++; if (obs_pc !== epc[i]) $display("FAIL bp_pc cyc=%0d got=%h exp=%h", i, obs_pc, epc[i]); else pass_cnt++;
      if (obs_deq) begin
        chk_cnt++;
        if (obs_under || {obs_pc, obs_instr} !== {exp_item.pc, exp_item.instr})
          $display("FAIL bp_sb got=%h/%h exp=%h/%h", obs_pc, obs_instr, exp_item.pc, exp_item.instr);
        else pass_cnt++;
      end
    end
    chk_cnt++; if (sb.size() != 0) $display("FAIL bp_drain got=%0d exp=0", sb.size()); else pass_cnt++;
  endtask

  task automatic test_flush();
    drv(1'b1, 32'h20, 32'hC020, 1'b0, 2'b00); step();
    drv(1'b1, 32'h24, 32'hC024, 1'b0, 2'b00); step();
    drv(1'b1, 32'h28, 32'hC028, 1'b0, 2'b01); step();
    chk_cnt++; if (obs_vld !== 1'b1 || obs_pc !== 32'h20) $display("FAIL fl2_pre got=%b/%h exp=1/20", obs_vld, obs_pc); else pass_cnt++;
    chk_cnt++; if (obs_rdy !== 1'b0) $display("FAIL fl2_rdy got=%b exp=0", obs_rdy); else pass_cnt++;
    drv(1'b0, 32'h0, 32'h0, 1'b1, 2'b00); step();
    chk_cnt++; if (obs_vld !== 1'b0) $display("FAIL fl2_vld got=%b exp=0", obs_vld); else pass_cnt++;
    chk_cnt++; if (obs_pc !== 32'h0) $display("FAIL fl2_pc got=%h exp=0", obs_pc); else pass_cnt++;
    chk_cnt++; if (obs_instr !== 32'h13) $display("FAIL fl2_instr got=%h exp=13", obs_instr); else pass_cnt++;
    chk_cnt++; if (obs_rdy !== 1'b1) $display("FAIL fl2_empty_rdy got=%b exp=1", obs_rdy); else pass_cnt++;
    drv(1'b1, 32'h30, 32'hC030, 1'b0, 2'b00); step();
    drv(1'b1, 32'h34, 32'hC034, 1'b0, 2'b01); step();
    chk_cnt++; if (obs_rdy !== 1'b1) $display("FAIL fl1_rdy got=%b exp=1", obs_rdy); else pass_cnt++;
    drv(1'b0, 32'h0, 32'h0, 1'b1, 2'b00); step();
    chk_cnt++; if (obs_vld !== 1'b0 || obs_instr !== 32'h13) $display("FAIL fl1_bubble got=%b/%h exp=0/13", obs_vld, obs_instr); else pass_cnt++;
    step();
    chk_cnt++; if (obs_vld !== 1'b0 || obs_pc !== 32'h0) $display("FAIL fl1_leak got=%b/%h exp=0/0", obs_vld, obs_pc); else pass_cnt++;
    chk_cnt++; if (sb.size() != 0) $display("FAIL fl_sb got=%0d exp=0", sb.size()); else pass_cnt++;
  endtask

  task automatic test_stall_flush();
    drv(1'b1, 32'h40, 32'hDEADBEEF, 1'b0, 2'b00); step();
    for (int i = 0; i < 2; i++) begin
      drv(1'b1, 32'h44, 32'h0000_0044, 1'b1, 2'b11);
      step();
      chk_cnt++; if (obs_rdy !== 1'b0) $display("FAIL st_rdy cyc=%0d got=%b exp=0", i, obs_rdy); else pass_cnt++;
      chk_cnt++; if (obs_vld !== 1'b1) $display("FAIL st_vld cyc=%0d got=%b exp=1", i, obs_vld); else pass_cnt++;
      chk_cnt++; if (obs_instr !== 32'hDEADBEEF) $display("FAIL st_instr cyc=%0d got=%h exp=deadbeef", i, obs_instr); else pass_cnt++;
    end
    drv(1'b0, 32'h0, 32'h0, 1'b1, 2'b00); step();
    chk_cnt++;
    if (!obs_deq || obs_under || {obs_pc, obs_instr} !== {exp_item.pc, exp_item.instr} || obs_instr !== 32'hDEADBEEF)
      $display("FAIL st_release got=%b/%h/%h exp=1/40/deadbeef", obs_vld, obs_pc, obs_instr);
    else pass_cnt++;
    step();
    chk_cnt++; if (obs_vld !== 1'b0) $display("FAIL st_after got=%b exp=0", obs_vld); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    drv(1'b1, 32'h60, 32'hC060, 1'b0, 2'b00); step();
    drv(1'b1, 32'h64, 32'hC064, 1'b0, 2'b00); step();
    rst = 1'b1;
    drv(1'b0, 32'h0, 32'h0, 1'b1, 2'b00); step();
    chk_cnt++; if (obs_vld !== 1'b0) $display("FAIL mid_rst_vld got=%b exp=0", obs_vld); else pass_cnt++;
    rst = 1'b0;
    step();
    chk_cnt++; if (obs_vld !== 1'b0 || obs_rdy !== 1'b1) $display("FAIL mid_rst_after got=%b/%b exp=0/1", obs_vld, obs_rdy); else pass_cnt++;
  endtask

  task automatic test_no_skid();
    logic        tv   [6] = '{1, 1, 1, 1, 0, 0};
    logic [31:0] tpc  [6] = '{32'h50, 32'h54, 32'h58, 32'h58, 32'h0, 32'h0};
    logic        tord [6] = '{1, 1, 0, 1, 1, 1};
    logic        erdy [6] = '{1, 1, 0, 1, 1, 1};
    logic        evld [6] = '{0, 1, 1, 1, 1, 0};
    logic [31:0] epc  [6] = '{32'h0, 32'h50, 32'h54, 32'h54, 32'h58, 32'h0};
    for (int i = 0; i < 6; i++) begin
      drv_b(tv[i], tpc[i], tord[i]);
      step();
      chk_cnt++; if (b_rdy !== erdy[i]) $display("FAIL ns_rdy cyc=%0d got=%b exp=%b", i, b_rdy, erdy[i]); else pass_cnt++;
      chk_cnt++; if (b_vld !== evld[i]) $display("FAIL ns_vld cyc=%0d got=%b exp=%b", i, b_vld, evld[i]); else pass_cnt++;
      chk_cnt++;
      if (b_pc !== epc[i] || b_instr !== (evld[i] ? (epc[i] ^ 32'h5A00_0000) : 32'h13))
        $display("FAIL ns_data cyc=%0d got=%h/%h exp pc=%h", i, b_pc, b_instr, epc[i]);
      else pass_cnt++;
    end
    drv_b(1'b0, 32'h0, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    drv(1'b0, 32'h0, 32'h0, 1'b0, 2'b00);
    drv_b(1'b0, 32'h0, 1'b0);
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_stall_flush();
    test_reset_mid();
    test_no_skid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
